// File: rtl/systolic_pass_ctrl.sv
// systolic_pass_ctrl: sequences one alignment through the systolic affine-gap array.
// The query is cut into N-base passes. Each pass loads its chunk into the PEs,
// streams the whole reference, then waits for the array to drain.
module systolic_pass_ctrl #(
  parameter int N          = 64,
  parameter int LOG_N      = 6,
  parameter int ADDR_W     = 10,
  parameter int BP_W       = 2,
  parameter int MEM_AMOUNT = 4,
  parameter int DRAIN_TO   = 2048
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             q_len,
  input  logic [ADDR_W-1:0]             r_len,
  output logic [ADDR_W-1:0]             q_addr,
  input  logic [BP_W-1:0]               q_data,
  output logic [ADDR_W-1:0]             r_addr,
  input  logic [BP_W-1:0]               r_data,
  output logic [BP_W-1:0]               S,
  output logic [BP_W-1:0]               T,
  output logic                          s_update,
  output logic                          valid,
  output logic                          ack,
  output logic                          new_seq,
  output logic                          use_s1,
  output logic [LOG_N-1:0]              PE_end,
  input  logic                          array_busy,
  output logic [$clog2(MEM_AMOUNT)-1:0] pass_idx,
  output logic                          done,
  output logic                          err
);

  localparam int PASS_W = $clog2(MEM_AMOUNT);
  localparam int NP_W   = ADDR_W + 1;
  localparam int TO_W   = $clog2(DRAIN_TO + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_NEXT   = 3'd4
  } state_t;

  state_t              state_r, state_n;
  logic [ADDR_W-1:0]   q_len_r, r_len_r, cnt_r, q_addr_r, r_addr_r;
  logic [PASS_W:0]     npass_r, npass_sel_s;
  logic [PASS_W-1:0]   pass_idx_r, pass_load_s;
  logic [LOG_N-1:0]    pe_end_r;
  logic [TO_W-1:0]     to_cnt_r;
  logic [NP_W-1:0]     npass_s;
  logic [ADDR_W-1:0]   qlen_sel_s;
  logic s_update_r, pad_r, valid_r, ack_r, new_seq_r, use_s1_r, done_r, err_r, busy_seen_r;
  logic accept_s, reject_s, last_load_s, last_stream_s, timeout_s, more_s, finish_s;

  // Last PE holding a real base: the tail of the query on the final pass, else the whole array.
  function automatic logic [LOG_N-1:0] pe_end_for(input logic [PASS_W-1:0] pass,
                                                   input logic [PASS_W:0]   npass,
                                                   input logic [ADDR_W-1:0] qlen);
    logic [ADDR_W-1:0] last_s;
    last_s = qlen - ADDR_W'(1);
    if ({1'b0, pass} == (npass - (PASS_W + 1)'(1))) pe_end_for = last_s[LOG_N-1:0];
    else                                           pe_end_for = {LOG_N{1'b1}};
  endfunction

  assign npass_s     = (NP_W'(q_len) + NP_W'(N - 1)) >> LOG_N;
  assign npass_sel_s = accept_s ? npass_s[PASS_W:0] : npass_r;
  assign pass_load_s = accept_s ? {PASS_W{1'b0}} : (pass_idx_r + PASS_W'(1));
  assign qlen_sel_s  = accept_s ? q_len : q_len_r;

  // Next-state decode and single-cycle event strobes.
  always_comb begin
    state_n       = state_r;
    accept_s      = 1'b0;
    reject_s      = 1'b0;
    last_load_s   = 1'b0;
    last_stream_s = 1'b0;
    timeout_s     = 1'b0;
    more_s        = 1'b0;
    finish_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if ((q_len == ADDR_W'(0)) || (r_len == ADDR_W'(0)) || (npass_s > NP_W'(MEM_AMOUNT))) begin
            reject_s = 1'b1;
            state_n  = ST_IDLE;
          end else begin
            accept_s = 1'b1;
            state_n  = ST_LOAD;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_r == ADDR_W'(N - 1)) begin
          last_load_s = 1'b1;
          state_n     = ST_STREAM;
        end else begin
          state_n = ST_LOAD;
        end
      end
      ST_STREAM: begin
        if (cnt_r == (r_len_r - ADDR_W'(1))) begin
          last_stream_s = 1'b1;
          state_n       = ST_DRAIN;
        end else begin
          state_n = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (busy_seen_r && !array_busy) begin
          state_n = ST_NEXT;
        end else if (to_cnt_r == TO_W'(DRAIN_TO - 1)) begin
          timeout_s = 1'b1;
          state_n   = ST_IDLE;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_NEXT: begin
        if (((PASS_W + 1)'(pass_idx_r) + (PASS_W + 1)'(1)) < npass_r) begin
          more_s  = 1'b1;
          state_n = ST_LOAD;
        end else begin
          finish_s = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State register, alignment context and status flags.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_r  <= ST_IDLE;
      q_len_r  <= {ADDR_W{1'b0}};
      r_len_r  <= {ADDR_W{1'b0}};
      npass_r  <= {(PASS_W + 1){1'b0}};
      use_s1_r <= 1'b0;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
      new_seq_r <= 1'b0;
      ack_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      new_seq_r <= accept_s;
      done_r    <= reject_s | timeout_s | finish_s;
      ack_r     <= (state_n == ST_LOAD) || (state_n == ST_STREAM);
      if (accept_s) begin
        q_len_r  <= q_len;
        r_len_r  <= r_len;
        npass_r  <= npass_s[PASS_W:0];
        use_s1_r <= ~use_s1_r;
        err_r    <= 1'b0;
      end else if (reject_s || timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Pass bookkeeping and buffer address generation; addresses idle at zero.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      pass_idx_r <= {PASS_W{1'b0}};
      pe_end_r   <= {LOG_N{1'b0}};
      cnt_r      <= {ADDR_W{1'b0}};
      q_addr_r   <= {ADDR_W{1'b0}};
      r_addr_r   <= {ADDR_W{1'b0}};
    end else if (accept_s || more_s) begin
      pass_idx_r <= pass_load_s;
      pe_end_r   <= pe_end_for(pass_load_s, npass_sel_s, qlen_sel_s);
      cnt_r      <= {ADDR_W{1'b0}};
      q_addr_r   <= ADDR_W'(pass_load_s) << LOG_N;
    end else if (state_r == ST_LOAD) begin
      cnt_r    <= last_load_s ? {ADDR_W{1'b0}} : (cnt_r + ADDR_W'(1));
      q_addr_r <= last_load_s ? {ADDR_W{1'b0}} : (q_addr_r + ADDR_W'(1));
    end else if (state_r == ST_STREAM) begin
      cnt_r    <= last_stream_s ? {ADDR_W{1'b0}} : (cnt_r + ADDR_W'(1));
      r_addr_r <= last_stream_s ? {ADDR_W{1'b0}} : (r_addr_r + ADDR_W'(1));
    end
  end

  // Beat strobes trail the issued address by one cycle to match the buffer read latency.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      s_update_r <= 1'b0;
      pad_r      <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      s_update_r <= (state_r == ST_LOAD);
      pad_r      <= (q_addr_r >= q_len_r);
      valid_r    <= (state_r == ST_STREAM);
    end
  end

  // Drain watchdog and busy-rise tracker, both cleared outside DRAIN.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      to_cnt_r    <= {TO_W{1'b0}};
      busy_seen_r <= 1'b0;
    end else if (state_r != ST_DRAIN) begin
      to_cnt_r    <= {TO_W{1'b0}};
      busy_seen_r <= 1'b0;
    end else begin
      to_cnt_r    <= to_cnt_r + TO_W'(1);
      busy_seen_r <= busy_seen_r | array_busy;
    end
  end

  assign S        = (s_update_r && !pad_r) ? q_data : {BP_W{1'b0}};
  assign T        = valid_r ? r_data : {BP_W{1'b0}};
  assign s_update = s_update_r;
  assign valid    = valid_r;
  assign ack      = ack_r;
  assign new_seq  = new_seq_r;
  assign use_s1   = use_s1_r;
  assign PE_end   = pe_end_r;
  assign pass_idx = pass_idx_r;
  assign done     = done_r;
  assign err      = err_r;
  assign q_addr   = q_addr_r;
  assign r_addr   = r_addr_r;

endmodule
